// File: rtl/decodificador_angulo_ascii_pkg.sv
// ============================================================================
// Module      : decodificador_angulo_ascii_pkg
// Description : ASCII constants, angle table and FSM state codes for the angle link.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decodificador_angulo_ascii_pkg;

    localparam logic [7:0] c_ascii_zero        = 8'h30;
    localparam logic [7:0] c_ascii_nove        = 8'h39;
    localparam logic [7:0] c_terminador_padrao = 8'h23;

    // Element i holds the angle for index i; shared with the transmit-side ROM.
    localparam logic [7:0][9:0] c_tabela_angulo = {
        10'd160, 10'd140, 10'd120, 10'd100,
        10'd80,  10'd60,  10'd40,  10'd20
    };

    localparam logic [2:0] c_ocioso = 3'd0;
    localparam logic [2:0] c_d2     = 3'd1;
    localparam logic [2:0] c_d3     = 3'd2;
    localparam logic [2:0] c_term   = 3'd3;
    localparam logic [2:0] c_valida = 3'd4;
    localparam logic [2:0] c_erro   = 3'd5;

    function automatic logic e_digito(input logic [7:0] b);
        return (b >= c_ascii_zero) && (b <= c_ascii_nove);
    endfunction

    // Returns {hit, index}; hit=0 when the angle is not in the table.
    function automatic logic [3:0] busca_indice(input logic [9:0] a);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (a == c_tabela_angulo[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decodificador_angulo_ascii_contador_timeout.sv
// ============================================================================
// Module      : decodificador_angulo_ascii_contador_timeout
// Description : Saturating inter-byte timeout counter with clear, enable and end flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decodificador_angulo_ascii_contador_timeout #(
    parameter int MODULO = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic limpa,
    input  logic habilita,
    output logic fim
);

    localparam int c_largura = (MODULO > 1) ? $clog2(MODULO) : 1;

    logic [c_largura-1:0] r_contagem;

    assign fim = (r_contagem == c_largura'(MODULO - 1));

    always_ff @(posedge clk) begin
        if (rst || limpa) begin
            r_contagem <= '0;
        end else if (habilita && !fim) begin
            r_contagem <= r_contagem + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decodificador_angulo_ascii.sv
// ============================================================================
// Module      : decodificador_angulo_ascii
// Description : Assembles "DDD"+terminator ASCII frames and recovers the angle index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decodificador_angulo_ascii
    import decodificador_angulo_ascii_pkg::*;
#(
    parameter logic [7:0] TERMINADOR     = c_terminador_padrao,
    parameter int         TIMEOUT_CICLOS = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] dado_ascii,
    input  logic       dado_valido,
    output logic [2:0] endereco,
    output logic [9:0] angulo,
    output logic       pronto,
    output logic       erro,
    output logic       ocupado,
    output logic [2:0] db_estado
);

    logic [2:0] r_estado;
    logic [2:0] w_proximo;
    logic [3:0] r_d1;
    logic [3:0] r_d2;
    logic [3:0] r_d3;
    logic       w_digito;
    logic       w_fim;
    logic       w_limpa;
    logic       w_habilita;
    logic [9:0] w_angulo;
    logic [3:0] w_busca;

    assign w_digito   = e_digito(dado_ascii);
    assign w_limpa    = (r_estado == c_ocioso) || dado_valido;
    assign w_habilita = (r_estado == c_d2) || (r_estado == c_d3) || (r_estado == c_term);

    decodificador_angulo_ascii_contador_timeout #(
        .MODULO   (TIMEOUT_CICLOS)
    ) u_timeout (
        .clk      (clock),
        .rst      (reset),
        .limpa    (w_limpa),
        .habilita (w_habilita),
        .fim      (w_fim)
    );

    // A strobed byte always takes priority over a timeout in the same cycle.
    always_comb begin
        w_proximo = r_estado;
        case (r_estado)
            c_ocioso: if (dado_valido && w_digito) w_proximo = c_d2;
            c_d2: begin
                if (dado_valido)  w_proximo = w_digito ? c_d3 : c_erro;
                else if (w_fim)   w_proximo = c_erro;
            end
            c_d3: begin
                if (dado_valido)  w_proximo = w_digito ? c_term : c_erro;
                else if (w_fim)   w_proximo = c_erro;
            end
            c_term: begin
                if (dado_valido)  w_proximo = (dado_ascii == TERMINADOR) ? c_valida : c_erro;
                else if (w_fim)   w_proximo = c_erro;
            end
            c_valida: w_proximo = c_ocioso;
            c_erro:   w_proximo = c_ocioso;
            default:  w_proximo = c_ocioso;
        endcase
    end

    assign w_angulo = 10'(r_d1) * 10'd100 + 10'(r_d2) * 10'd10 + 10'(r_d3);
    assign w_busca  = busca_indice(w_angulo);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado <= c_ocioso;
            r_d1     <= 4'd0;
            r_d2     <= 4'd0;
            r_d3     <= 4'd0;
            endereco <= 3'd0;
            angulo   <= 10'd0;
        end else begin
            r_estado <= w_proximo;
            if (dado_valido && w_digito) begin
                case (r_estado)
                    c_ocioso: r_d1 <= dado_ascii[3:0];
                    c_d2:     r_d2 <= dado_ascii[3:0];
                    c_d3:     r_d3 <= dado_ascii[3:0];
                    default:  ;
                endcase
            end
            if ((r_estado == c_valida) && w_busca[3]) begin
                endereco <= w_busca[2:0];
                angulo   <= w_angulo;
            end
        end
    end

    assign pronto    = (r_estado == c_valida) && w_busca[3];
    assign erro      = (r_estado == c_erro) || ((r_estado == c_valida) && !w_busca[3]);
    assign ocupado   = (r_estado != c_ocioso);
    assign db_estado = r_estado;

endmodule

`default_nettype wire
